axi_lite_reg_selftest: RTL and testbench

Parametrised, synthesizable AXI4-Lite master that runs a write/read-back/compare self-test over NUM_REGS consecutive slave registers and reports pass/fail, error count and first failing index. It is the in-fabric successor of the BFM register test: it sits beside a peripheral such as the frame counter, drives that peripheral's S_AXI port directly, and needs no simulator-only BFM. It adds two ordering modes, generated test data, response checking and a per-transaction watchdog.

---
 rtl/axi_lite_pkg.sv | 52 +++++
 rtl/axi_lite_wr_channel.sv | 66 ++++++
 rtl/axi_lite_reg_selftest.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_lite_reg_selftest.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite register self-test master:
//   - AXI response codes
//   - self-test FSM state encoding
//   - rotl / gen_data test-data generation (data_i = rotl(seed, i mod DW) ^ i)
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_ADVANCE,
    S_FINISH
  } state_t;

  // Rotate the low 'width' bits of value left by (amount mod width).
  // Bits above 'width' are ignored and returned as zero.
  function automatic logic [63:0] rotl(input logic [63:0] value,
                                       input int unsigned amount,
                                       input int unsigned width);
    logic [63:0] mask;
    logic [63:0] v;
    int unsigned a;
    a    = amount % width;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    v    = value & mask;
    rotl = ((v << a) | (v >> (width - a))) & mask;
  endfunction

  // Test pattern for register idx.
  function automatic logic [63:0] gen_data(input logic [63:0] seed,
                                           input int unsigned idx,
                                           input int unsigned width);
    gen_data = rotl(seed, idx, width) ^ 64'(idx);
  endfunction

  // EXOKAY is not a legal AXI4-Lite response, so it is treated as bad too.
  function automatic logic resp_bad(input logic [1:0] resp);
    resp_bad = (resp == RESP_EXOKAY) || (resp == RESP_SLVERR) ||
               (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_wr_channel.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_channel
// AW/W handshake tracker for an AXI4-Lite master. A launch pulse raises
// AWVALID and WVALID on the next edge; each valid drops on its own handshake.
// both_done is high in the cycle where the second (or both) handshake lands.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   launch         start a new write address/data pair
//   abort          drop both valids immediately (dead-slave abort)
//   awready/wready slave ready inputs
//   awvalid/wvalid registered valid outputs
//   both_done      both handshakes complete (combinational on registered state)
//   idle           no write in flight
// -----------------------------------------------------------------------------
module axi_lite_wr_channel (
  input  logic clk,
  input  logic reset,
  input  logic launch,
  input  logic abort,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic both_done,
  output logic idle
);

  logic aw_done;
  logic w_done;
  logic aw_ok;
  logic w_ok;

  assign aw_ok     = aw_done | (awvalid & awready);
  assign w_ok      = w_done  | (wvalid & wready);
  assign both_done = aw_ok & w_ok;
  assign idle      = ~(awvalid | wvalid | aw_done | w_done);

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (launch) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (both_done) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (wvalid && wready) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_selftest.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_selftest
// AXI4-Lite master that writes a generated pattern to NUM_REGS consecutive
// slave registers, reads them back and compares. Reports pass/fail, a
// saturating error count, the first failing index and a watchdog timeout.
// Ports:
//   ACLK, ARESET       clock, synchronous active-high reset
//   start, mode, seed  test launch (mode 0 interleaved, 1 batched)
//   busy, done, pass   status; done/pass held until the next accepted start
//   err_count          mismatches + bad responses (saturating)
//   first_fail_idx     index of the first failing register
//   timeout            per-transaction watchdog fired
//   M_AXI_*            AXI4-Lite master port
// -----------------------------------------------------------------------------
module axi_lite_reg_selftest
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDXW = $clog2(NUM_REGS + 1)
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  input  logic                            mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [IDXW:0]                   err_count,
  output logic [IDXW-1:0]                 first_fail_idx,
  output logic                            timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW  = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW  = C_M_AXI_DATA_WIDTH;
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REGS - 1);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            mode_q;
  logic            rd_phase;
  logic [DW-1:0]   seed_q;
  logic [WDW-1:0]  wdog;

  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_data;
  logic            in_wait;
  logic            progress;
  logic            abort;
  logic            wr_launch;
  logic            wr_both;
  logic            wr_idle;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  assign cur_addr = BASE_ADDR + AW'(ADDR_STRIDE) * AW'(idx);
  assign cur_data = DW'(gen_data(64'(seed_q), 32'(idx), DW));

  always_comb begin
    in_wait  = 1'b0;
    progress = 1'b0;
    case (state)
      S_WR_REQ:  begin in_wait = 1'b1; progress = wr_both; end
      S_WR_RESP: begin in_wait = 1'b1; progress = M_AXI_BVALID; end
      S_RD_REQ:  begin in_wait = 1'b1; progress = M_AXI_ARVALID && M_AXI_ARREADY; end
      S_RD_RESP: begin in_wait = 1'b1; progress = M_AXI_RVALID; end
      default:   begin in_wait = 1'b0; progress = 1'b0; end
    endcase
  end

  // A handshake landing in the watchdog's final cycle still wins over the abort.
  assign abort     = in_wait && (wdog == WD_LAST) && !progress;
  assign wr_launch = (state == S_WR_REQ) && wr_idle && !abort;

  axi_lite_wr_channel u_wr_channel (
    .clk       (ACLK),
    .reset     (ARESET),
    .launch    (wr_launch),
    .abort     (abort),
    .awready   (M_AXI_AWREADY),
    .wready    (M_AXI_WREADY),
    .awvalid   (M_AXI_AWVALID),
    .wvalid    (M_AXI_WVALID),
    .both_done (wr_both),
    .idle      (wr_idle)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state          <= S_IDLE;
      idx            <= '0;
      mode_q         <= 1'b0;
      rd_phase       <= 1'b0;
      seed_q         <= '0;
      wdog           <= '0;
      M_AXI_AWADDR   <= '0;
      M_AXI_WDATA    <= '0;
      M_AXI_ARADDR   <= '0;
      M_AXI_ARVALID  <= 1'b0;
      M_AXI_BREADY   <= 1'b0;
      M_AXI_RREADY   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      timeout        <= 1'b0;
    end else if (abort) begin
      M_AXI_ARVALID <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      timeout       <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b1;
      pass          <= 1'b0;
      state         <= S_FINISH;
    end else begin
      if (in_wait) wdog <= wdog + 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_WR_REQ;
            idx            <= '0;
            rd_phase       <= 1'b0;
            mode_q         <= mode;
            seed_q         <= seed;
            wdog           <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            timeout        <= 1'b0;
          end
        end

        S_WR_REQ: begin
          if (wr_launch) begin
            M_AXI_AWADDR <= cur_addr;
            M_AXI_WDATA  <= cur_data;
          end
          if (wr_both) begin
            M_AXI_BREADY <= 1'b1;
            state        <= S_WR_RESP;
            wdog         <= '0;
          end
        end

        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (resp_bad(M_AXI_BRESP)) begin
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (err_count == '0) first_fail_idx <= idx;
            end
            state <= mode_q ? S_ADVANCE : S_RD_REQ;
            wdog  <= '0;
          end
        end

        S_RD_REQ: begin
          if (!M_AXI_ARVALID) begin
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARADDR  <= cur_addr;
          end else if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_RD_RESP;
            wdog          <= '0;
          end
        end

        S_RD_RESP: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            // Bad response and data mismatch on one beat are a single error.
            if (resp_bad(M_AXI_RRESP) || (M_AXI_RDATA != cur_data)) begin
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (err_count == '0) first_fail_idx <= idx;
            end
            state <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          if (idx == LAST_IDX) begin
            if (!mode_q || rd_phase) begin
              state <= S_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !timeout;
            end else begin
              idx      <= '0;
              rd_phase <= 1'b1;
              state    <= S_RD_REQ;
              wdog     <= '0;
            end
          end else begin
            idx   <= idx + 1'b1;
            wdog  <= '0;
            state <= (mode_q && rd_phase) ? S_RD_REQ : S_WR_REQ;
          end
        end

        S_FINISH: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_selftest.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_reg_selftest
// Directed bench for axi_lite_reg_selftest with a small configurable
// AXI4-Lite register slave (AWREADY delay, stuck bit, SLVERR injection,
// dead AR channel) and a valid/payload stability monitor.
// Expected pattern: data_i = rotl(seed, i) ^ i, hand-computed below.
// -----------------------------------------------------------------------------
module tb_axi_lite_reg_selftest;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [DW-1:0] seed;
  logic          busy, done, pass, timeout;
  logic [3:0]    err_count;
  logic [2:0]    first_fail_idx;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_reg_selftest #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .NUM_REGS           (NR),
    .BASE_ADDR          (32'h0),
    .ADDR_STRIDE        (4),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .ACLK           (clk),
    .ARESET         (rst),
    .start          (start),
    .mode           (mode),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx),
    .timeout        (timeout),
    .M_AXI_AWADDR   (awaddr),
    .M_AXI_AWPROT   (awprot),
    .M_AXI_AWVALID  (awvalid),
    .M_AXI_AWREADY  (awready),
    .M_AXI_WDATA    (wdata),
    .M_AXI_WSTRB    (wstrb),
    .M_AXI_WVALID   (wvalid),
    .M_AXI_WREADY   (wready),
    .M_AXI_BRESP    (bresp),
    .M_AXI_BVALID   (bvalid),
    .M_AXI_BREADY   (bready),
    .M_AXI_ARADDR   (araddr),
    .M_AXI_ARPROT   (arprot),
    .M_AXI_ARVALID  (arvalid),
    .M_AXI_ARREADY  (arready),
    .M_AXI_RDATA    (rdata),
    .M_AXI_RRESP    (rresp),
    .M_AXI_RVALID   (rvalid),
    .M_AXI_RREADY   (rready)
  );

  // ---------------- slave model ----------------
  int          aw_delay;
  int          slverr_idx;
  logic        stuck_en;
  logic        ar_never;
  logic        clr;

  logic [31:0] mem [NR];
  int          aw_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [31:0] wr_addr, wr_data;
  int          wr_idx;
  int          aw_hs_cnt, ar_hs_cnt, aw_before_ar, viol;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = !ar_never;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign wr_addr = aw_got ? aw_addr_q : awaddr;
  assign wr_data = w_got ? w_data_q : wdata;
  assign wr_idx  = int'(wr_addr[3:2]);
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs) && !bvalid;

  always @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NR; i++) mem[i] <= '0;
      aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      aw_hs_cnt <= 0; ar_hs_cnt <= 0; aw_before_ar <= -1;
    end else begin
      if (aw_hs || !awvalid) aw_cnt <= 0;
      else aw_cnt <= aw_cnt + 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= awaddr; aw_hs_cnt <= aw_hs_cnt + 1; end
      if (w_hs) begin w_got <= 1'b1; w_data_q <= wdata; end
      if (wr_fire) begin
        mem[wr_idx] <= (stuck_en && wr_idx == 2) ? (wr_data & ~32'h10) : wr_data;
        bvalid <= 1'b1;
        bresp  <= (wr_idx == slverr_idx) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= mem[int'(araddr[3:2])];
        rresp  <= 2'b00;
        ar_hs_cnt <= ar_hs_cnt + 1;
        if (ar_hs_cnt == 0) aw_before_ar <= aw_hs_cnt;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Valid/payload stability monitor; a timeout abort is the one allowed drop.
  always @(posedge clk) begin
    if (rst) begin
      viol <= 0;
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0;
    end else begin
      if (!timeout) begin
        if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) viol <= viol + 1;
        if (p_wv && !p_wr && (!wvalid || wdata != p_wdata))      viol <= viol + 1;
        if (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) viol <= viol + 1;
      end
      p_awv <= awvalid; p_awr <= awready; p_wv <= wvalid; p_wr <= wready;
      p_arv <= arvalid; p_arr <= arready;
      p_awaddr <= awaddr; p_wdata <= wdata; p_araddr <= araddr;
    end
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},    64'(busy), 0);
    chk({tag, "_done"},    64'(done), 0);
    chk({tag, "_pass"},    64'(pass), 0);
    chk({tag, "_err"},     64'(err_count), 0);
    chk({tag, "_first"},   64'(first_fail_idx), 0);
    chk({tag, "_timeout"}, 64'(timeout), 0);
    chk({tag, "_valids"},  64'({awvalid, wvalid, arvalid}), 0);
    chk({tag, "_readys"},  64'({bready, rready}), 0);
    chk({tag, "_awaddr"},  64'(awaddr), 0);
    chk({tag, "_araddr"},  64'(araddr), 0);
    chk({tag, "_wdata"},   64'(wdata), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic [DW-1:0] s);
    mode = m; seed = s; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(done), 1);
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    chk({tag, "_m0"}, 64'(mem[0]), 64'(e0));
    chk({tag, "_m1"}, 64'(mem[1]), 64'(e1));
    chk({tag, "_m2"}, 64'(mem[2]), 64'(e2));
    chk({tag, "_m3"}, 64'(mem[3]), 64'(e3));
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; clr = 1'b0;
    aw_delay = 0; slverr_idx = -1; stuck_en = 1'b0; ar_never = 1'b0;
    tick(3);
    chk_reset("rst0");
    chk("rst0_prot_strb", 64'({awprot, arprot, wstrb}), 64'h00F);
    rst = 1'b0;
    tick(1);

    // T1: mode 0, seed 0x0101FFFF; 7 cycles/reg -> done visible 28 edges after start
    do_start(1'b0, 32'h0101FFFF);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_awvalid_entry", 64'(awvalid), 0);
    tick(1);
    chk("t1_awvalid_rise", 64'({awvalid, wvalid}), 3);
    chk("t1_awaddr0", 64'(awaddr), 0);
    chk("t1_wdata0", 64'(wdata), 64'h0101FFFF);
    tick(26);
    chk("t1_done_early", 64'(done), 0);
    tick(1);
    chk("t1_done", 64'(done), 1);
    chk("t1_busy_end", 64'(busy), 0);
    chk("t1_pass", 64'(pass), 1);
    chk("t1_err", 64'(err_count), 0);
    chk("t1_timeout", 64'(timeout), 0);
    chk("t1_last_awaddr", 64'(awaddr), 64'hC);
    chk("t1_last_araddr", 64'(araddr), 64'hC);
    chk("t1_aw_before_ar", 64'(aw_before_ar), 1);
    chk_mem("t1", 32'h0101FFFF, 32'h0203FFFF, 32'h0407FFFE, 32'h080FFFFB);
    tick(3);
    chk("t1_done_held", 64'({done, pass}), 3);

    // T2: mode 1 (4+4 cycles/reg -> 32), start while busy ignored, start clears done
    do_clr();
    do_start(1'b1, 32'h0101FFFF);
    chk("t2_done_cleared", 64'(done), 0);
    start = 1'b1; mode = 1'b0; seed = '0;
    tick(1);
    start = 1'b0;
    tick(30);
    chk("t2_done_early", 64'(done), 0);
    tick(1);
    chk("t2_done", 64'(done), 1);
    chk("t2_pass", 64'(pass), 1);
    chk("t2_err", 64'(err_count), 0);
    chk("t2_aw_before_ar", 64'(aw_before_ar), 4);
    chk_mem("t2", 32'h0101FFFF, 32'h0203FFFF, 32'h0407FFFE, 32'h080FFFFB);

    // T2b: rotate wrap of the MSB
    do_clr();
    do_start(1'b0, 32'h80000001);
    wait_done(60, "t2b_done");
    chk("t2b_pass", 64'(pass), 1);
    chk_mem("t2b", 32'h80000001, 32'h00000002, 32'h00000004, 32'h0000000F);

    // T3: bit 4 of register 2 stuck at 0
    do_clr();
    stuck_en = 1'b1;
    do_start(1'b0, 32'h0101FFFF);
    wait_done(60, "t3_done");
    chk("t3_err", 64'(err_count), 1);
    chk("t3_first", 64'(first_fail_idx), 2);
    chk("t3_pass", 64'(pass), 0);
    chk("t3_timeout", 64'(timeout), 0);
    stuck_en = 1'b0;

    // T4: SLVERR on write to register 1, AWREADY delayed 5 cycles
    do_clr();
    aw_delay = 5; slverr_idx = 1;
    do_start(1'b0, 32'h0101FFFF);
    wait_done(200, "t4_done");
    chk("t4_err", 64'(err_count), 1);
    chk("t4_first", 64'(first_fail_idx), 1);
    chk("t4_pass", 64'(pass), 0);
    chk("t4_viol", 64'(viol), 0);
    chk("t4_mem1", 64'(mem[1]), 64'h0203FFFF);
    aw_delay = 0; slverr_idx = -1;

    // T5: dead AR channel; RD_REQ entered 3 edges after start, aborts 16 cycles later
    do_clr();
    ar_never = 1'b1;
    do_start(1'b0, 32'h0101FFFF);
    tick(18);
    chk("t5_pre_timeout", 64'({timeout, arvalid}), 1);
    tick(1);
    chk("t5_timeout", 64'(timeout), 1);
    chk("t5_done", 64'(done), 1);
    chk("t5_pass", 64'(pass), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 0);
    chk("t5_err", 64'(err_count), 0);
    chk("t5_viol", 64'(viol), 0);
    ar_never = 1'b0;

    // T6: reset during WR_RESP of register 2, then a clean restart
    do_clr();
    do_start(1'b0, 32'h0101FFFF);
    n = 0;
    while (!(bready && awaddr == 32'h8) && n < 40) begin
      tick(1);
      n++;
    end
    chk("t6_in_wr_resp2", 64'(bready && awaddr == 32'h8), 1);
    rst = 1'b1;
    tick(1);
    chk_reset("t6_rst");
    rst = 1'b0;
    tick(1);
    do_start(1'b0, 32'h0101FFFF);
    tick(1);
    chk("t6_restart_awaddr", 64'(awaddr), 0);
    chk("t6_restart_wdata", 64'(wdata), 64'h0101FFFF);
    wait_done(60, "t6_done");
    chk("t6_pass", 64'(pass), 1);
    chk_mem("t6", 32'h0101FFFF, 32'h0203FFFF, 32'h0407FFFE, 32'h080FFFFB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
